spm_serial_ctrl: RTL and testbench
==================================

SPM_SERIAL_CTRL -- requirements
Module: spm_serial_ctrl

Interface
REQ-001 The block SHALL have parameter WIDTH, default 32, giving the operand width in bits (minimum 2).
REQ-002 The block SHALL have parameter LAT, default 1, giving the cycles from a y bit on spm_y to the matching product bit on spm_p (range 0..3).
REQ-003 Port clk, input, 1: the single clock; all state updates on its rising edge.
REQ-004 Port rst, input, 1: reset, synchronous and active-high.
REQ-005 Port in_valid, input, 1: operand pair valid.
REQ-006 Port in_ready, output, 1: block can accept an operand pair.
REQ-007 Port in_x, input, WIDTH: signed multiplicand, parallel.
REQ-008 Port in_y, input, WIDTH: signed multiplier, serialised by the block.
REQ-009 Port spm_x, output, WIDTH: parallel multiplicand to the spm array.
REQ-010 Port spm_y, output, 1: serial multiplier bit to the spm array, LSB first.
REQ-011 Port spm_clr, output, 1: clears the spm array's internal carry/sum registers.
REQ-012 Port spm_p, input, 1: serial product bit from the spm array.
REQ-013 Port out_valid, output, 1: product valid.
REQ-014 Port out_ready, input, 1: downstream accepts the product.
REQ-015 Port out_product, output, 2*WIDTH: signed two's-complement product in_x*in_y.

Function
REQ-016 The FSM SHALL have exactly four states, IDLE, CLEAR, SHIFT and DONE, plus a cycle counter cnt of ceil(log2(2*WIDTH+LAT+1)) bits.
REQ-017 in_ready SHALL be 1 only in IDLE; in_valid&&in_ready SHALL capture in_x and in_y into x_reg and y_reg and move IDLE->CLEAR.
REQ-018 CLEAR SHALL last exactly one cycle with spm_clr=1 and spm_y=0, then move to SHIFT with cnt=0.
REQ-019 spm_x SHALL equal x_reg in CLEAR, SHIFT and DONE, and 0 in IDLE.
REQ-020 In SHIFT, spm_y SHALL be y_reg[cnt] for cnt<WIDTH, y_reg[WIDTH-1] (sign extension) for WIDTH<=cnt<2*WIDTH, and 0 for cnt>=2*WIDTH.
REQ-021 In SHIFT, when cnt>=LAT, the block SHALL shift spm_p into the MSB of the 2*WIDTH product register, shifting the register right by one.
REQ-022 SHIFT SHALL last exactly 2*WIDTH+LAT cycles, cnt 0..2*WIDTH+LAT-1, then move to DONE.
REQ-023 In DONE, out_valid SHALL be 1 and out_product SHALL be the held product register; out_product SHALL stay stable while out_valid=1 and out_ready=0.
REQ-024 out_valid&&out_ready in DONE SHALL move DONE->IDLE; the next operand SHALL NOT be accepted in that same cycle.
REQ-025 Latency SHALL be fixed: with acceptance in cycle T, out_valid SHALL first be 1 in cycle T+2*WIDTH+LAT+2, independent of data.
REQ-026 in_valid while not in IDLE SHALL be ignored with no effect on state.
REQ-027 out_ready while out_valid=0 SHALL be ignored.
REQ-028 spm_clr SHALL be 0 in IDLE, SHIFT and DONE except during reset.

Reset
REQ-029 With rst=1 at a clock edge, the block SHALL enter IDLE and clear cnt, x_reg, y_reg and the product register; this takes priority over every other event.
REQ-030 During and after reset until a new operand is accepted, outputs SHALL be: in_ready=1, out_valid=0, out_product=0, spm_x=0, spm_y=0.
REQ-031 spm_clr SHALL be 1 in any cycle where rst=1, so the spm array is cleared alongside the controller.
REQ-032 Reset asserted mid-SHIFT or in DONE SHALL abort the operation with no out_valid pulse; the pending product SHALL be discarded.

Verification (WIDTH=8, LAT=1, behavioural spm model with 1-cycle output register)
REQ-033 Operands x=3, y=5, accepted at T -> out_valid=1 at T+19 with out_product=0x000F.
REQ-034 Operands x=0xFD (-3), y=0x05 -> out_product=0xFFF1; operands x=0x80, y=0x80 -> out_product=0x4000.
REQ-035 Operands x=0x7F, y=0x7F with out_ready held 0 for 5 cycles after out_valid -> out_product=0x3F01 stable throughout, in_ready=0 throughout; IDLE one cycle after out_ready=1.
REQ-036 rst=1 for one cycle at SHIFT cnt=6 -> next cycle in_ready=1, out_valid=0, spm_clr=1 in the reset cycle only; a new operand pair x=2, y=-1 then yields 0xFFFE.
REQ-037 Back-to-back: in_valid held 1 with two queued operand pairs and out_ready tied 1 -> second acceptance exactly one cycle after the first product's handshake; both products correct; no in_valid acceptance outside IDLE.

Source files
------------

// File: rtl/spm_serial_ctrl.sv
// Controller that feeds a serial/parallel multiplier (spm) array: it holds the
// multiplicand in parallel, streams the sign-extended multiplier LSB first and
// collects the serial product into a 2*WIDTH-bit register.
module spm_serial_ctrl #(
    parameter int WIDTH = 32,
    parameter int LAT   = 1
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [WIDTH-1:0]     in_x,
    input  logic [WIDTH-1:0]     in_y,
    output logic [WIDTH-1:0]     spm_x,
    output logic                 spm_y,
    output logic                 spm_clr,
    input  logic                 spm_p,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [2*WIDTH-1:0]   out_product,
    output logic [1:0]           o_dbg_state
);

    localparam int CW = $clog2(2*WIDTH + LAT + 1);
    localparam int IW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

    localparam logic [CW-1:0] C_W    = CW'(WIDTH);
    localparam logic [CW-1:0] C_2W   = CW'(2*WIDTH);
    localparam logic [CW-1:0] C_LAT  = CW'(LAT);
    localparam logic [CW-1:0] C_LAST = CW'(2*WIDTH + LAT - 1);
    localparam logic [CW-1:0] C_ONE  = CW'(1);

    // Handshakes: a transfer happens on a rising edge where valid && ready.
    // in_ready is high only in IDLE; out_valid is high only in DONE and the
    // product is held unchanged until out_ready is seen.
    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        CLEAR = 2'd1,
        SHIFT = 2'd2,
        DONE  = 2'd3
    } state_t;

    state_t               r_state;
    logic [CW-1:0]        r_cnt;
    logic [WIDTH-1:0]     r_x;
    logic [WIDTH-1:0]     r_y;
    logic [2*WIDTH-1:0]   r_prod;
    logic                 r_in_ready;
    logic                 r_out_valid;
    logic                 w_spm_y;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= IDLE;
            r_cnt       <= '0;
            r_x         <= '0;
            r_y         <= '0;
            r_prod      <= '0;
            r_in_ready  <= 1'b1;
            r_out_valid <= 1'b0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (in_valid && r_in_ready) begin
                        r_x        <= in_x;
                        r_y        <= in_y;
                        r_in_ready <= 1'b0;
                        r_state    <= CLEAR;
                    end
                end
                CLEAR: begin
                    r_cnt   <= '0;
                    r_prod  <= '0;
                    r_state <= SHIFT;
                end
                SHIFT: begin
                    // The first LAT cycles only fill the array's output pipeline.
                    if (r_cnt >= C_LAT) begin
                        r_prod <= {spm_p, r_prod[2*WIDTH-1:1]};
                    end
                    if (r_cnt == C_LAST) begin
                        r_out_valid <= 1'b1;
                        r_state     <= DONE;
                    end else begin
                        r_cnt <= r_cnt + C_ONE;
                    end
                end
                DONE: begin
                    if (out_ready) begin
                        r_out_valid <= 1'b0;
                        r_in_ready  <= 1'b1;
                        r_state     <= IDLE;
                    end
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    // Multiplier bits beyond WIDTH repeat the sign so the low 2*WIDTH product
    // bits are correct for signed operands; zeros flush the array afterwards.
    always_comb begin
        w_spm_y = 1'b0;
        if (r_state == SHIFT) begin
            if (r_cnt < C_W) begin
                w_spm_y = r_y[r_cnt[IW-1:0]];
            end else if (r_cnt < C_2W) begin
                w_spm_y = r_y[WIDTH-1];
            end
        end
    end

    assign in_ready    = r_in_ready;
    assign out_valid   = r_out_valid;
    assign out_product = r_prod;
    assign spm_x       = (r_state == IDLE) ? '0 : r_x;
    assign spm_y       = w_spm_y;
    assign spm_clr     = rst || (r_state == CLEAR);
    assign o_dbg_state = r_state;

endmodule

// File: tb/tb_spm_serial_ctrl.sv
// Directed bench for spm_serial_ctrl (WIDTH=8, LAT=1) with a behavioural spm
// array whose product bit appears one cycle after the matching multiplier bit.
module tb_spm_serial_ctrl;

  localparam int W   = 8;
  localparam int LAT = 1;
  localparam int EXP_LAT = 2*W + LAT + 2;

  logic           clk;
  logic           rst;
  logic           in_valid;
  logic           in_ready;
  logic [W-1:0]   in_x;
  logic [W-1:0]   in_y;
  logic [W-1:0]   spm_x;
  logic           spm_y;
  logic           spm_clr;
  logic           spm_p;
  logic           out_valid;
  logic           out_ready;
  logic [2*W-1:0] out_product;
  logic [1:0]     dbg_state;

  int n_checks;
  int n_fail;

  spm_serial_ctrl #(.WIDTH(W), .LAT(LAT)) dut (
    .clk         (clk),
    .rst         (rst),
    .in_valid    (in_valid),
    .in_ready    (in_ready),
    .in_x        (in_x),
    .in_y        (in_y),
    .spm_x       (spm_x),
    .spm_y       (spm_y),
    .spm_clr     (spm_clr),
    .spm_p       (spm_p),
    .out_valid   (out_valid),
    .out_ready   (out_ready),
    .out_product (out_product),
    .o_dbg_state (dbg_state)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // behavioural spm array: accumulate x when the y bit is set, emit the LSB
  longint m_acc;
  longint m_sum;
  logic   m_p;

  always_comb begin
    m_sum = m_acc + (spm_y ? longint'($signed(spm_x)) : 64'sd0);
  end

  always @(posedge clk) begin
    if (spm_clr) begin
      m_acc <= 0;
      m_p   <= 1'b0;
    end else begin
      m_acc <= m_sum >>> 1;
      m_p   <= m_sum[0];
    end
  end

  assign spm_p = m_p;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // one full operation; hold = cycles out_ready stays low after out_valid
  task automatic run_op(input logic [W-1:0] x, input logic [W-1:0] y,
                        input logic [2*W-1:0] exp, input int hold);
    int k;
    bit seen;
    @(negedge clk);
    check_eq("ready_before_op", in_ready, 1);
    in_x = x;
    in_y = y;
    in_valid = 1'b1;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    in_x = 8'hAA;
    in_y = 8'h55;
    seen = 1'b0;
    k = 0;
    for (int i = 1; i <= 60 && !seen; i++) begin
      @(negedge clk);
      k = i;
      if (i == 1) begin
        check_eq("clear_spm_clr", spm_clr, 1);
        check_eq("clear_spm_y", spm_y, 0);
        check_eq("clear_spm_x", spm_x, x);
        check_eq("busy_in_ready", in_ready, 0);
      end
      if (i == 2) begin
        check_eq("shift_spm_clr", spm_clr, 0);
        check_eq("shift_y0", spm_y, y[0]);
      end
      if (out_valid) seen = 1'b1;
    end
    check_eq("latency", seen ? k : 0, EXP_LAT);
    check_eq("product", out_product, exp);
    // in_valid during DONE must be ignored
    in_valid = 1'b1;
    in_x = 8'h11;
    in_y = 8'h22;
    for (int i = 0; i < hold; i++) begin
      @(negedge clk);
      check_eq("hold_product", out_product, exp);
      check_eq("hold_valid", out_valid, 1);
      check_eq("hold_in_ready", in_ready, 0);
    end
    in_valid = 1'b0;
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    out_ready = 1'b0;
    @(negedge clk);
    check_eq("idle_in_ready", in_ready, 1);
    check_eq("idle_out_valid", out_valid, 0);
  endtask

  logic [W-1:0]   bx [2];
  logic [W-1:0]   by [2];
  logic [2*W-1:0] bp [2];
  int acc_cyc [2];
  int hs_cyc [2];
  int nacc;
  int nhs;
  int vcount;
  bit acc_now;

  initial begin
    n_checks  = 0;
    n_fail    = 0;
    rst       = 1'b1;
    in_valid  = 1'b0;
    in_x      = '0;
    in_y      = '0;
    out_ready = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    check_eq("rst_spm_clr", spm_clr, 1);
    check_eq("rst_in_ready", in_ready, 1);
    rst = 1'b0;
    @(negedge clk);
    check_eq("post_rst_in_ready", in_ready, 1);
    check_eq("post_rst_out_valid", out_valid, 0);
    check_eq("post_rst_product", out_product, 0);
    check_eq("post_rst_spm_x", spm_x, 0);
    check_eq("post_rst_spm_y", spm_y, 0);
    check_eq("post_rst_spm_clr", spm_clr, 0);

    // out_ready without out_valid has no effect
    out_ready = 1'b1;
    repeat (3) @(negedge clk);
    check_eq("stray_out_ready_valid", out_valid, 0);
    check_eq("stray_out_ready_ready", in_ready, 1);
    out_ready = 1'b0;

    run_op(8'h03, 8'h05, 16'h000F, 0);
    run_op(8'hFD, 8'h05, 16'hFFF1, 0);
    run_op(8'h80, 8'h80, 16'h4000, 0);
    run_op(8'h7F, 8'h7F, 16'h3F01, 5);

    // reset in the middle of SHIFT (cnt = 6)
    @(negedge clk);
    in_x = 8'h05;
    in_y = 8'h09;
    in_valid = 1'b1;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    repeat (8) @(negedge clk);
    rst = 1'b1;
    #1;
    check_eq("midrst_spm_clr", spm_clr, 1);
    @(negedge clk);
    rst = 1'b0;
    #1;
    check_eq("midrst_in_ready", in_ready, 1);
    check_eq("midrst_out_valid", out_valid, 0);
    check_eq("midrst_spm_clr_off", spm_clr, 0);
    check_eq("midrst_product", out_product, 0);
    check_eq("midrst_spm_x", spm_x, 0);
    vcount = 0;
    repeat (25) begin
      @(negedge clk);
      if (out_valid) vcount++;
    end
    check_eq("midrst_no_valid", vcount, 0);
    run_op(8'h02, 8'hFF, 16'hFFFE, 0);

    // back-to-back with in_valid held and out_ready tied high
    bx[0] = 8'h12; by[0] = 8'h34; bp[0] = 16'h03A8;
    bx[1] = 8'h9C; by[1] = 8'h07; bp[1] = 16'hFD44;
    nacc = 0;
    nhs = 0;
    @(negedge clk);
    in_x = bx[0];
    in_y = by[0];
    in_valid = 1'b1;
    out_ready = 1'b1;
    for (int c = 0; c < 100 && nhs < 2; c++) begin
      if (c > 0) @(negedge clk);
      acc_now = in_valid && in_ready;
      if (out_valid) begin
        check_eq("b2b_product", out_product, bp[nhs]);
        check_eq("b2b_latency", c - acc_cyc[nhs], EXP_LAT);
        hs_cyc[nhs] = c;
        nhs++;
      end
      if (acc_now) begin
        if (nacc < 2) acc_cyc[nacc] = c;
        nacc++;
      end
      @(posedge clk);
      #1;
      if (acc_now) begin
        if (nacc < 2) begin
          in_x = bx[nacc];
          in_y = by[nacc];
        end else begin
          in_valid = 1'b0;
        end
      end
    end
    in_valid = 1'b0;
    out_ready = 1'b0;
    check_eq("b2b_accepts", nacc, 2);
    check_eq("b2b_handshakes", nhs, 2);
    check_eq("b2b_second_accept", acc_cyc[1], hs_cyc[0] + 1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
